acc_unit: RTL and testbench
===========================

ACC_UNIT -- requirements
Module: acc_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 11, meaning two's-complement data width of src, acc and bak.
REQ-002 SHALL have parameter SAT_MAX, default 999, meaning the saturation magnitude; legal range is 1 to 2^(DATA_W-1)-1.
REQ-003 SHALL have parameter MUL_EN, default 1, meaning MUL opcode is implemented (1) or decoded as NOP (0).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port op_valid, input, 1, meaning op and src are presented.
REQ-007 SHALL have port op_ready, output, 1, meaning the unit can accept an op this cycle.
REQ-008 SHALL have port op, input, 3, meaning the opcode: 0 NOP, 1 MOV, 2 ADD, 3 SUB, 4 NEG, 5 SWP, 6 SAV, 7 MUL.
REQ-009 SHALL have port src, input, DATA_W, meaning the signed operand.
REQ-010 SHALL have port acc, output, DATA_W, meaning the registered signed accumulator.
REQ-011 SHALL have port bak, output, DATA_W, meaning the registered signed backup register.
REQ-012 SHALL have port busy, output, 1, meaning a multi-cycle MUL is in progress.
REQ-013 SHALL have port sat, output, 1, meaning a one-cycle pulse, high the cycle after a write to acc that was clamped.

Function
REQ-014 SHALL accept an op exactly on a rising edge where op_valid and op_ready are both high; op and src are sampled only on that edge.
REQ-015 SHALL hold op_ready = !busy, combinationally, with no dependence on op_valid.
REQ-016 SHALL implement a two-state FSM: IDLE (busy=0) and MUL (busy=1); every op except MUL is accepted and completed in IDLE.
REQ-017 SHALL complete single-cycle ops with acc and bak updated on the acceptance edge and visible in the following cycle; back-to-back accepts every cycle are permitted.
REQ-018 SHALL compute MOV as acc=clamp(src), ADD as acc=clamp(acc+src), SUB as acc=clamp(acc-src) and NEG as acc=clamp(-acc), with each intermediate at DATA_W+1 bits so no wrap occurs before clamping.
REQ-019 SHALL compute SWP as acc=bak and bak=acc simultaneously, SAV as bak=acc with acc unchanged, and NOP as no change; these ops never assert sat.
REQ-020 SHALL define clamp(x) as SAT_MAX if x>SAT_MAX, -SAT_MAX if x<-SAT_MAX, else x; clamp asserts sat when it alters x.
REQ-021 SHALL, on accepting MUL with MUL_EN=1, capture acc and src, enter MUL and compute the 2*DATA_W-bit signed product by iterative shift-add, one partial step per cycle, for DATA_W cycles.
REQ-022 SHALL write acc=clamp(product) on the DATA_W-th edge after the acceptance edge, return to IDLE on that same edge and raise op_ready in the following cycle; bak is unchanged.
REQ-023 SHALL ignore op, src and op_valid while in MUL; acc and bak hold their pre-MUL values until the final write.
REQ-024 SHALL decode MUL as NOP when MUL_EN=0, with no state entry and no sat.
REQ-025 SHALL handle the most negative src (-2^(DATA_W-1)) correctly in all ops, with the result saturating rather than overflowing.

Reset
REQ-026 SHALL, on any edge with rst=1, set acc=0, bak=0, sat=0, FSM=IDLE and the MUL counter to 0; rst has priority over any accepted op.
REQ-027 SHALL abort an in-progress MUL on reset, discarding the partial product, with op_ready=1 in the cycle after reset deasserts.

Verification
REQ-028 SHALL pass this test: reset, then MOV 500, then ADD 600 -> acc=999 and sat pulses for exactly one cycle; then SUB -5 -> acc=999 and sat=1 again.
REQ-029 SHALL pass this test: MOV -7, then MUL 6 -> busy=1 for 11 cycles, op_ready=0 throughout, acc=-42 after completion and sat=0; an op_valid pulse with ADD 1 held during busy is ignored.
REQ-030 SHALL pass this test: MOV 40, then MUL 30 -> acc=999 and sat=1; MOV -40, then MUL 30 -> acc=-999.
REQ-031 SHALL pass this test: MOV 12, SAV, MOV 3, SWP -> acc=12 and bak=3; then NEG -> acc=-12.
REQ-032 SHALL pass this test: MUL accepted, then rst asserted for 1 cycle on the 5th busy cycle -> acc=0, bak=0, busy=0 and op_ready=1 afterwards; a following MOV 1 gives acc=1.
REQ-033 SHALL pass this test: with MUL_EN=0, MOV 9, then MUL 2 -> acc stays 9, busy never asserts and the next op is accepted in the following cycle.

Source files
------------

// File: rtl/acc_unit_if.sv
// Operation/result bundle between an issuing agent and acc_unit.
// Latency: none (wires only).
// Backpressure: op_valid/op_ready handshake; the issuer holds op/src until op_ready is seen.
//
// Signals:
//   op_valid  master->slave  op and src are presented
//   op        master->slave  3-bit opcode (NOP MOV ADD SUB NEG SWP SAV MUL)
//   src       master->slave  signed operand, DATA_W bits
//   op_ready  slave->master  slave accepts an op this cycle
//   acc, bak  slave->master  registered signed accumulator / backup
//   busy      slave->master  multi-cycle MUL in progress
//   sat       slave->master  one-cycle pulse after a clamped acc write
interface acc_unit_if #(
  parameter int DATA_W = 11
);
  logic                     op_valid;
  logic                     op_ready;
  logic [2:0]               op;
  logic signed [DATA_W-1:0] src;
  logic signed [DATA_W-1:0] acc;
  logic signed [DATA_W-1:0] bak;
  logic                     busy;
  logic                     sat;

  modport master (
    output op_valid, op, src,
    input  op_ready, acc, bak, busy, sat
  );

  modport slave (
    input  op_valid, op, src,
    output op_ready, acc, bak, busy, sat
  );
endinterface

// File: rtl/acc_unit.sv
// Saturating accumulator with backup register and an iterative shift-add multiplier.
// Latency: single-cycle ops update acc/bak on the accept edge; MUL writes acc DATA_W edges after accept.
// Backpressure: op_ready = !busy; while a MUL is iterating, op/src/op_valid are ignored.
//
// Ports:
//   clk   rising-edge clock for all state
//   rst   synchronous active-high reset; aborts any MUL in flight
//   bus   acc_unit_if.slave: op_valid/op/src in, op_ready/acc/bak/busy/sat out
module acc_unit #(
  parameter int DATA_W  = 11,
  parameter int SAT_MAX = 999,
  parameter bit MUL_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  acc_unit_if.slave  bus
);

  // Working width for every pre-clamp result: wide enough for the full
  // product, so sums, differences and negations can never wrap either.
  localparam int PW    = 2 * DATA_W;
  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic signed [PW-1:0] SAT_HI   = PW'(SAT_MAX);
  localparam logic signed [PW-1:0] SAT_LO   = -SAT_HI;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_MOV = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_NEG = 3'd4,
    OP_SWP = 3'd5,
    OP_SAV = 3'd6,
    OP_MUL = 3'd7
  } op_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [DATA_W-1:0] acc_q, acc_d;
  logic signed [DATA_W-1:0] bak_q, bak_d;
  logic                     sat_q, sat_d;
  logic signed [PW-1:0]     mcand_q, mcand_d;   // captured acc, shifted left once per step
  logic [DATA_W-1:0]        mplier_q, mplier_d; // captured src, shifted right once per step
  logic signed [PW-1:0]     prod_q, prod_d;     // running partial product

  logic signed [PW-1:0]     acc_x;
  logic signed [PW-1:0]     src_x;
  logic signed [PW-1:0]     part;
  logic signed [PW-1:0]     prod_nxt;
  logic signed [PW-1:0]     res_wide;
  logic                     wr_acc;
  logic [DATA_W:0]          clamp_res;

  // Returns {clip, value}: value is x limited to +/-SAT_MAX, clip flags an alteration.
  function automatic logic [DATA_W:0] clamp_f(input logic signed [PW-1:0] x);
    logic signed [PW-1:0] y;
    logic                 clip;
    y    = x;
    clip = 1'b0;
    if (x > SAT_HI) begin
      y    = SAT_HI;
      clip = 1'b1;
    end else if (x < SAT_LO) begin
      y    = SAT_LO;
      clip = 1'b1;
    end
    return {clip, y[DATA_W-1:0]};
  endfunction

  assign acc_x = {{(PW - DATA_W){acc_q[DATA_W-1]}}, acc_q};
  assign src_x = {{(PW - DATA_W){bus.src[DATA_W-1]}}, bus.src};

  // Two's-complement shift-add: the multiplier MSB carries weight -2^(DATA_W-1),
  // so the last step subtracts its partial product instead of adding it.
  assign part     = mplier_q[0] ? mcand_q : '0;
  assign prod_nxt = (cnt_q == CNT_LAST) ? (prod_q - part) : (prod_q + part);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    bak_d    = bak_q;
    sat_d    = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    res_wide = '0;
    wr_acc   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.op_valid) begin
          case (op_t'(bus.op))
            OP_MOV: begin
              res_wide = src_x;
              wr_acc   = 1'b1;
            end
            OP_ADD: begin
              res_wide = acc_x + src_x;
              wr_acc   = 1'b1;
            end
            OP_SUB: begin
              res_wide = acc_x - src_x;
              wr_acc   = 1'b1;
            end
            OP_NEG: begin
              res_wide = -acc_x;
              wr_acc   = 1'b1;
            end
            OP_SWP: begin
              acc_d = bak_q;
              bak_d = acc_q;
            end
            OP_SAV: begin
              bak_d = acc_q;
            end
            OP_MUL: begin
              if (MUL_EN) begin
                state_d  = S_MUL;
                cnt_d    = '0;
                mcand_d  = acc_x;
                mplier_d = bus.src;
                prod_d   = '0;
              end
            end
            default: ;
          endcase
        end
      end

      S_MUL: begin
        mcand_d  = mcand_q <<< 1;
        mplier_d = mplier_q >> 1;
        prod_d   = prod_nxt;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          res_wide = prod_nxt;
          wr_acc   = 1'b1;
          state_d  = S_IDLE;
          cnt_d    = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    clamp_res = clamp_f(res_wide);
    if (wr_acc) begin
      acc_d = clamp_res[DATA_W-1:0];
      sat_d = clamp_res[DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      bak_q    <= '0;
      sat_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      bak_q    <= bak_d;
      sat_q    <= sat_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  assign bus.op_ready = (state_q == S_IDLE);
  assign bus.busy     = (state_q == S_MUL);
  assign bus.acc      = acc_q;
  assign bus.bak      = bak_q;
  assign bus.sat      = sat_q;

endmodule

// File: tb/tb_acc_unit.sv
// Scoreboard bench for acc_unit: a driver issues directed then random ops and
// pushes model results; a negedge monitor pops and compares on each completion.
// A second instance with MUL disabled gets a short directed check.
module tb_acc_unit;

  localparam int DW  = 11;
  localparam int SAT = 999;

  localparam logic [2:0] NOP = 3'd0, MOV = 3'd1, ADD = 3'd2, SUB = 3'd3,
                         NEG = 3'd4, SWP = 3'd5, SAV = 3'd6, MUL = 3'd7;

  typedef struct {
    int acc;
    int bak;
    int sat;
  } exp_t;

  logic clk;
  logic rst;

  acc_unit_if #(.DATA_W(DW)) bus();
  acc_unit_if #(.DATA_W(DW)) bus2();

  acc_unit #(.DATA_W(DW), .SAT_MAX(SAT), .MUL_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  acc_unit #(.DATA_W(DW), .SAT_MAX(SAT), .MUL_EN(1'b0)) dut_nomul (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  int   m_acc = 0;
  int   m_bak = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int clampi(input int x);
    if (x > SAT) return SAT;
    if (x < -SAT) return -SAT;
    return x;
  endfunction

  // Reference behaviour: plain integer arithmetic, then clamp.
  task automatic model_apply(input logic [2:0] op, input int s);
    exp_t e;
    int   raw;
    int   t;
    e.sat = 0;
    case (op)
      MOV, ADD, SUB, NEG, MUL: begin
        case (op)
          MOV:     raw = s;
          ADD:     raw = m_acc + s;
          SUB:     raw = m_acc - s;
          NEG:     raw = -m_acc;
          default: raw = m_acc * s;
        endcase
        m_acc = clampi(raw);
        e.sat = (m_acc != raw) ? 1 : 0;
      end
      SWP: begin
        t     = m_acc;
        m_acc = m_bak;
        m_bak = t;
      end
      SAV: m_bak = m_acc;
      default: ;
    endcase
    e.acc = m_acc;
    e.bak = m_bak;
    sb_q.push_back(e);
  endtask

  task automatic push_reset();
    exp_t e;
    m_acc = 0;
    m_bak = 0;
    e.acc = 0;
    e.bak = 0;
    e.sat = 0;
    sb_q.push_back(e);
  endtask

  // All driver tasks start and end at posedge+1.
  task automatic wait_ready();
    int n = 0;
    while (!bus.op_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("ready_timeout", 0, 1);
  endtask

  task automatic do_op(input logic [2:0] op, input int s);
    int n = 0;
    // While busy, drive junk that must be ignored (first an ADD 1 pulse).
    while (!bus.op_ready && n < 100) begin
      bus.op_valid = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.op       = (n == 0) ? ADD : 3'($urandom_range(0, 7));
      bus.src      = (n == 0) ? 11'sd1 : 11'($urandom_range(0, 2047));
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      chk("issue_timeout", 0, 1);
    end else begin
      bus.op_valid = 1'b1;
      bus.op       = op;
      bus.src      = 11'(s);
      model_apply(op, s);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle();
    bus.op_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic reset_cycle();
    bus.op_valid = 1'b0;
    wait_ready();
    rst = 1'b1;
    push_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: completion = cycle after a non-MUL accept, busy falling, or reset.
  initial begin : monitor
    bit   p_rst, p_fire, p_busy, have;
    int   busy_run, cur_acc, cur_bak, a, b;
    exp_t e;
    p_rst = 0; p_fire = 0; p_busy = 0; have = 0;
    busy_run = 0; cur_acc = 0; cur_bak = 0;
    forever begin
      @(negedge clk);
      a = bus.acc;
      b = bus.bak;
      if (p_rst || p_fire || (p_busy && !bus.busy)) begin
        if (!p_rst && p_busy) chk("busy_cycles", busy_run, DW);
        if (p_rst) begin
          chk("rst_busy", int'(bus.busy), 0);
          chk("rst_ready", int'(bus.op_ready), 1);
        end
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 0, 1);
        end else begin
          e = sb_q.pop_front();
          chk("acc", a, e.acc);
          chk("bak", b, e.bak);
          chk("sat", int'(bus.sat), e.sat);
          cur_acc = e.acc;
          cur_bak = e.bak;
          have    = 1;
        end
      end else if (have) begin
        chk("sat_idle", int'(bus.sat), 0);
        chk("acc_hold", a, cur_acc);
        chk("bak_hold", b, cur_bak);
      end
      if (have) chk("ready_vs_busy", int'(bus.op_ready), int'(!bus.busy));
      busy_run = bus.busy ? busy_run + 1 : 0;
      p_rst  = rst;
      p_fire = bus.op_valid && bus.op_ready && !rst && (bus.op != MUL);
      p_busy = bus.busy;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached, required bench completion");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int s;
    int r;
    rst           = 1'b1;
    bus.op_valid  = 1'b0;
    bus.op        = NOP;
    bus.src       = '0;
    bus2.op_valid = 1'b0;
    bus2.op       = NOP;
    bus2.src      = '0;
    @(posedge clk); #1;
    reset_cycle();

    // MUL disabled: MUL acts as NOP and the next op is accepted at once.
    bus2.op_valid = 1'b1; bus2.op = MOV; bus2.src = 11'sd9;
    @(posedge clk); #1;
    bus2.op = MUL; bus2.src = 11'sd2;
    @(posedge clk); #1;
    chk("nomul_acc", int'(bus2.acc), 9);
    chk("nomul_busy", int'(bus2.busy), 0);
    chk("nomul_ready", int'(bus2.op_ready), 1);
    chk("nomul_sat", int'(bus2.sat), 0);
    bus2.op = ADD; bus2.src = 11'sd1;
    @(posedge clk); #1;
    chk("nomul_next", int'(bus2.acc), 10);
    bus2.op_valid = 1'b0;

    // Saturation on ADD, pulse drops, saturates again on SUB.
    do_op(MOV, 500);
    do_op(ADD, 600);
    idle();
    idle();
    do_op(SUB, -5);
    idle();

    // MUL small product, then saturating products of both signs.
    do_op(MOV, -7);
    do_op(MUL, 6);
    do_op(MOV, 40);
    do_op(MUL, 30);
    do_op(MOV, -40);
    do_op(MUL, 30);

    // Backup register ops.
    do_op(MOV, 12);
    do_op(SAV, 0);
    do_op(MOV, 3);
    do_op(SWP, 0);
    do_op(NEG, 0);

    // Most negative operand.
    do_op(MOV, -1024);
    do_op(SUB, -1024);
    do_op(MUL, -1024);
    do_op(NEG, 0);
    do_op(MUL, -1024);

    // Reset on the 5th busy cycle aborts the MUL.
    do_op(MOV, 77);
    do_op(SAV, 0);
    do_op(MUL, 5);
    bus.op_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    void'(sb_q.pop_back());
    push_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(MOV, 1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 9))
        0:       s = -1024;
        1:       s = 1023;
        2:       s = 0;
        default: s = $urandom_range(0, 2047) - 1024;
      endcase
      if (r < 2) reset_cycle();
      else if (r < 12) idle();
      else do_op(3'($urandom_range(0, 7)), s);
    end

    bus.op_valid = 1'b0;
    wait_ready();
    repeat (3) idle();
    chk("sb_drain", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
